regfile_mp: RTL

Parametrised multi-port register file with write-port arbitration and a per-register busy scoreboard. It replaces the single-write, dual-read register file in the datapath. Reads are combinational. Writes commit on the clock edge. A scoreboard marks registers that have an outstanding write so the controller can stall on read-after-write hazards.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_mp.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, the read-address vector type and the write-priority select
// used by the multi-port register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_SIZE       = 8;
  localparam int DEFAULT_NRD        = 2;
  localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_SIZE);

  typedef logic [DEFAULT_NRD*DEFAULT_ADDR_WIDTH-1:0] rd_addr_vec_t;

  typedef enum logic [1:0] {
    WSRC_NONE,
    WSRC_PORT0,
    WSRC_PORT1
  } wsrc_e;

  // Port 1 wins whenever both write ports hit the same register.
  function automatic wsrc_e write_source(input logic hit0, input logic hit1);
    if (hit1) return WSRC_PORT1;
    if (hit0) return WSRC_PORT0;
    return WSRC_NONE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one flag per register, set on reserve, cleared by a write,
// with reserve taking priority when both target the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int SIZE       = DEFAULT_SIZE,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write0,
  input  logic [ADDR_WIDTH-1:0] writenum0,
  input  logic                  write1,
  input  logic [ADDR_WIDTH-1:0] writenum1,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reservenum,
  output logic [SIZE-1:0]       busy_all
);

  logic [SIZE-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (write0) busy_d[writenum0] = 1'b0;
    if (write1) busy_d[writenum1] = 1'b0;
    // NOTE: blocking assignments in order; the reserve is assigned last so a
    // newer producer keeps the register busy over a same-edge write.
    if (reserve) busy_d[reservenum] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_all = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two arbitrated write ports, NRD combinational read
// ports and a busy scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SIZE       = DEFAULT_SIZE,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int NRD        = DEFAULT_NRD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write0,
  input  logic [ADDR_WIDTH-1:0]     writenum0,
  input  logic [WIDTH-1:0]          data_in0,
  input  logic                      write1,
  input  logic [ADDR_WIDTH-1:0]     writenum1,
  input  logic [WIDTH-1:0]          data_in1,
  input  logic                      reserve,
  input  logic [ADDR_WIDTH-1:0]     reservenum,
  input  logic [NRD*ADDR_WIDTH-1:0] readnum,
  output logic [NRD*WIDTH-1:0]      data_out,
  output logic [NRD-1:0]            busy_out,
  output logic [SIZE-1:0]           busy_all,
  output logic                      conflict
);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] mem_d [SIZE];
  logic [SIZE-1:0]  wr_hot0, wr_hot1;

  assign wr_hot0  = write0 ? (SIZE'(1) << writenum0) : '0;
  assign wr_hot1  = write1 ? (SIZE'(1) << writenum1) : '0;
  assign conflict = write0 && write1 && (writenum0 == writenum1);

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      mem_d[i] = mem_q[i];
      case (write_source(wr_hot0[i], wr_hot1[i]))
        WSRC_PORT1: mem_d[i] = data_in1;
        WSRC_PORT0: mem_d[i] = data_in0;
        default:    ;
      endcase
    end
  end

  // NOTE: the storage array is reset on purpose: reads are visible straight
  // after reset and must return zero, so this stays a flop array, not a RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (reset) mem_q[i] <= '0;
      else       mem_q[i] <= mem_d[i];
    end
  end

  regfile_scoreboard #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .write0     (write0),
    .writenum0  (writenum0),
    .write1     (write1),
    .writenum1  (writenum1),
    .reserve    (reserve),
    .reservenum (reservenum),
    .busy_all   (busy_all)
  );

`ifdef REGFILE_BYPASS_EN
  logic [SIZE-1:0] res_hot;
  assign res_hot = reserve ? (SIZE'(1) << reservenum) : '0;
`endif

  for (genvar g = 0; g < NRD; g++) begin : gen_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_busy;

    assign addr = readnum[g*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_data = mem_q[addr];
      rd_busy = busy_all[addr];
`ifdef REGFILE_BYPASS_EN
      case (write_source(wr_hot0[addr], wr_hot1[addr]))
        WSRC_PORT1: rd_data = data_in1;
        WSRC_PORT0: rd_data = data_in0;
        default:    ;
      endcase
      if ((wr_hot0[addr] || wr_hot1[addr]) && !res_hot[addr]) rd_busy = 1'b0;
`endif
    end

    assign data_out[g*WIDTH +: WIDTH] = rd_data;
    assign busy_out[g]                = rd_busy;
  end

endmodule
